// File: rtl/ppf_bank.sv
// Polyphase filter bank: per-channel TAP_NUM-deep FIR over accepted sample sets,
// with programmable per-channel coefficients and a two-stage product/sum pipeline.
module ppf_bank #(
    parameter int unsigned CH_NUM  = 8,
    parameter int unsigned TAP_NUM = 4,
    parameter int unsigned DIN_W   = 32,
    parameter int unsigned COEF_W  = 16,
    parameter int unsigned DOUT_W  = 64
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              data_valid_i,
    input  logic [CH_NUM*DIN_W-1:0]           data_i,
    input  logic                              clear_i,
    input  logic                              coef_we_i,
    input  logic [$clog2(CH_NUM*TAP_NUM)-1:0] coef_addr_i,
    input  logic [COEF_W-1:0]                 coef_data_i,
    output logic                              data_valid_o,
    output logic [CH_NUM*DOUT_W-1:0]          data_o,
    output logic                              fill_done_o
);

    localparam int unsigned PROD_W = DIN_W + COEF_W;
    localparam int unsigned ADDR_W = $clog2(CH_NUM * TAP_NUM);
    localparam int unsigned CNT_W  = $clog2(TAP_NUM + 1);

    if (DOUT_W < DIN_W + COEF_W + $clog2(TAP_NUM)) begin : g_width_chk
        $error("ppf_bank: DOUT_W too narrow for exact accumulation");
    end

    logic signed [DIN_W-1:0]  hist_q   [CH_NUM][TAP_NUM];
    logic signed [COEF_W-1:0] coef_q   [CH_NUM][TAP_NUM];
    // Coefficients one edge behind the write port, aligned with the history they multiply.
    logic signed [COEF_W-1:0] coef_d_q [CH_NUM][TAP_NUM];
    logic signed [PROD_W-1:0] prod_q   [CH_NUM][TAP_NUM];
    logic signed [DOUT_W-1:0] sum      [CH_NUM];

    logic             hist_vld_q;
    logic             prod_vld_q;
    logic [CNT_W-1:0] fill_cnt_q;
    logic [CNT_W-1:0] fill_nxt;

    // Saturating fill count for the next accepted sample
    always_comb begin
        fill_nxt = fill_cnt_q;
        if (fill_cnt_q != CNT_W'(TAP_NUM)) begin
            fill_nxt = fill_cnt_q + CNT_W'(1);
        end
    end

    // Sample history, fill tracking and first valid stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                for (int t = 0; t < TAP_NUM; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
            hist_vld_q  <= 1'b0;
            fill_cnt_q  <= '0;
            fill_done_o <= 1'b0;
        end else if (clear_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                for (int t = 0; t < TAP_NUM; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
            hist_vld_q  <= 1'b0;
            fill_cnt_q  <= '0;
            fill_done_o <= 1'b0;
        end else if (data_valid_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                hist_q[c][0] <= $signed(data_i[c*DIN_W +: DIN_W]);
                for (int t = 1; t < TAP_NUM; t++) begin
                    hist_q[c][t] <= hist_q[c][t-1];
                end
            end
            hist_vld_q  <= 1'b1;
            fill_cnt_q  <= fill_nxt;
            fill_done_o <= (fill_nxt == CNT_W'(TAP_NUM));
        end else begin
            hist_vld_q <= 1'b0;
        end
    end

    // Coefficient store; resets to pass-through, unaffected by clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                for (int t = 0; t < TAP_NUM; t++) begin
                    coef_q[c][t]   <= (t == 0) ? COEF_W'(1) : '0;
                    coef_d_q[c][t] <= (t == 0) ? COEF_W'(1) : '0;
                end
            end
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                for (int t = 0; t < TAP_NUM; t++) begin
                    coef_d_q[c][t] <= coef_q[c][t];
                    if (coef_we_i && coef_addr_i == ADDR_W'(c * TAP_NUM + t)) begin
                        coef_q[c][t] <= $signed(coef_data_i);
                    end
                end
            end
        end
    end

    // Stage 1: all products
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                for (int t = 0; t < TAP_NUM; t++) begin
                    prod_q[c][t] <= '0;
                end
            end
            prod_vld_q <= 1'b0;
        end else if (clear_i) begin
            prod_vld_q <= 1'b0;
        end else begin
            prod_vld_q <= hist_vld_q;
            if (hist_vld_q) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    for (int t = 0; t < TAP_NUM; t++) begin
                        prod_q[c][t] <= PROD_W'(hist_q[c][t]) * PROD_W'(coef_d_q[c][t]);
                    end
                end
            end
        end
    end

    // Per-channel sign-extended accumulation of the registered products
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            sum[c] = '0;
            for (int t = 0; t < TAP_NUM; t++) begin
                sum[c] = sum[c] + DOUT_W'(prod_q[c][t]);
            end
        end
    end

    // Stage 2: output register; data holds when no new result arrives
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else if (clear_i) begin
            data_valid_o <= 1'b0;
        end else begin
            data_valid_o <= prod_vld_q;
            if (prod_vld_q) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    data_o[c*DOUT_W +: DOUT_W] <= sum[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_ppf_bank.sv
// Randomized scoreboard bench for ppf_bank against an arithmetic reference model.
module tb_ppf_bank;

    localparam int CH    = 6;
    localparam int TAPS  = 4;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int OW    = 64;
    localparam int NCOEF = CH * TAPS;
    localparam int AW    = $clog2(NCOEF);

    logic              clk;
    logic              rstn;
    logic              dvi;
    logic [CH*DW-1:0]  din;
    logic              clr;
    logic              we;
    logic [AW-1:0]     addr;
    logic [CW-1:0]     cdata;
    logic              dvo;
    logic [CH*OW-1:0]  dout;
    logic              fdone;

    ppf_bank #(
        .CH_NUM (CH),
        .TAP_NUM(TAPS),
        .DIN_W  (DW),
        .COEF_W (CW),
        .DOUT_W (OW)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .data_valid_i(dvi),
        .data_i      (din),
        .clear_i     (clr),
        .coef_we_i   (we),
        .coef_addr_i (addr),
        .coef_data_i (cdata),
        .data_valid_o(dvo),
        .data_o      (dout),
        .fill_done_o (fdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [CH*OW-1:0] y;
    } exp_t;

    exp_t             sbq[$];
    longint           hist_m[CH][TAPS];
    longint           coef_m[CH][TAPS];
    int               fill_m;
    int               edge_cnt = 0;
    logic [CH*OW-1:0] last_out;
    int               total = 0;
    int               bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [CH*OW-1:0] act, input logic [CH*OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int t = 0; t < TAPS; t++) begin
                hist_m[c][t] = 0;
                coef_m[c][t] = (t == 0) ? 1 : 0;
            end
        fill_m   = 0;
        last_out = '0;
        sbq.delete();
    endtask

    // Drive one cycle of inputs and advance the reference model to the upcoming edge.
    task automatic step(input logic v, input logic [CH*DW-1:0] d, input logic c_in,
                        input logic w, input logic [AW-1:0] a, input logic [CW-1:0] cd);
        int                e;
        exp_t              ex;
        logic signed [DW-1:0] s;
        logic signed [CW-1:0] sc;
        longint            acc;
        @(negedge clk);
        dvi = v; din = d; clr = c_in; we = w; addr = a; cdata = cd;
        e = edge_cnt + 1;
        if (c_in) begin
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < TAPS; t++) hist_m[c][t] = 0;
            fill_m = 0;
            while (sbq.size() > 0 && sbq[$].due >= e) void'(sbq.pop_back());
        end else if (v) begin
            for (int c = 0; c < CH; c++) begin
                for (int t = TAPS - 1; t > 0; t--) hist_m[c][t] = hist_m[c][t-1];
                s = d[c*DW +: DW];
                hist_m[c][0] = longint'(s);
                acc = 0;
                for (int t = 0; t < TAPS; t++) acc += coef_m[c][t] * hist_m[c][t];
                ex.y[c*OW +: OW] = acc;
            end
            ex.due = e + 2;
            sbq.push_back(ex);
            if (fill_m < TAPS) fill_m++;
        end
        if (w && int'(a) < NCOEF) begin
            sc = cd;
            coef_m[int'(a) / TAPS][int'(a) % TAPS] = longint'(sc);
        end
        @(posedge clk);
        #1;
        chk("fill_done", {{(CH*OW-1){1'b0}}, fdone}, {{(CH*OW-1){1'b0}}, (fill_m == TAPS)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wcoef(input int a, input int val);
        step(1'b0, '0, 1'b0, 1'b1, AW'(a), CW'(val));
    endtask

    function automatic logic [CH*DW-1:0] ch0_only(input int val);
        logic [CH*DW-1:0] d;
        d = '0;
        d[DW-1:0] = DW'(val);
        return d;
    endfunction

    function automatic logic [CH*DW-1:0] rand_set();
        logic [CH*DW-1:0] d;
        for (int c = 0; c < CH; c++) d[c*DW +: DW] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0; dvi = 1'b0; clr = 1'b0; we = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", {{(CH*OW-1){1'b0}}, dvo}, '0);
        chk("rst_async_data", dout, '0);
        chk("rst_async_fill", {{(CH*OW-1){1'b0}}, fdone}, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: pop on each presented result, otherwise require held data and no overdue result
    always @(negedge clk) begin
        exp_t ex;
        if (dvo) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: got data %h at edge %0d, want no output", dout, edge_cnt);
            end else begin
                ex = sbq.pop_front();
                chk("latency", CH*OW'(edge_cnt), CH*OW'(ex.due));
                chk("data", dout, ex.y);
                last_out = ex.y;
            end
        end else begin
            chk("hold", dout, last_out);
            if (sbq.size() > 0 && sbq[0].due <= edge_cnt) begin
                total++; bad++;
                $display("FAIL missing_valid: got none at edge %0d, want result due %0d", edge_cnt, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [CH*DW-1:0] d;
        rstn = 1'b0; dvi = 1'b0; din = '0; clr = 1'b0; we = 1'b0; addr = '0; cdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Pass-through: channel c carries c+1
        for (int c = 0; c < CH; c++) d[c*DW +: DW] = DW'(c + 1);
        repeat (3) step(1'b1, d, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Ramp coefficients on channel 0, fresh history
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        for (int t = 0; t < TAPS; t++) wcoef(t, t + 1);
        for (int i = 1; i <= 5; i++) step(1'b1, ch0_only(i), 1'b0, 1'b0, '0, '0);
        idle(3);

        // Coefficient write coincident with a sample on channel 1
        d = '0; d[DW +: DW] = DW'(7);
        step(1'b1, d, 1'b0, 1'b1, AW'(TAPS), CW'(-2));
        step(1'b1, d, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Out-of-range coefficient addresses are ignored
        for (int a = NCOEF; a < (1 << AW); a++) wcoef(a, int'($urandom_range(0, 65535)));
        repeat (3) step(1'b1, rand_set(), 1'b0, 1'b0, '0, '0);
        idle(3);

        // Clear with two results in flight
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        repeat (5) step(1'b1, rand_set(), 1'b0, 1'b0, '0, '0);
        step(1'b1, rand_set(), 1'b1, 1'b0, '0, '0);
        idle(3);
        step(1'b1, rand_set(), 1'b0, 1'b0, '0, '0);
        idle(3);

        // Extreme values must accumulate without wrap
        step(1'b0, '0, 1'b1, 1'b0, '0, '0);
        for (int t = 0; t < TAPS; t++) wcoef(t, 32'h7FFF);
        repeat (4) step(1'b1, ch0_only(32'h7FFF_FFFF), 1'b0, 1'b0, '0, '0);
        idle(3);

        // Random traffic with sparse clears and coefficient writes
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, rand_set(), ($urandom % 40) == 0, ($urandom % 5) == 0,
                 AW'($urandom_range(0, (1 << AW) - 1)), CW'($urandom));
        end

        // Reset mid-stream drops in-flight results and restores pass-through
        repeat (2) step(1'b1, rand_set(), 1'b0, 1'b0, '0, '0);
        do_reset();
        repeat (4) step(1'b1, rand_set(), 1'b0, 1'b0, '0, '0);
        idle(5);

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
